c2_mem_initiator: RTL



---
 rtl/c2_pkg.sv | 33 +++
 rtl/c2_tristate_drv.sv | 17 +
 rtl/c2_mem_initiator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/c2_pkg.sv
// c2_pkg: shared definitions for the C2 memory bus initiator.
//   - bus geometry constants (line address width, data bus width, line size)
//   - derived beat count and beat counter width
//   - C2 command encoding and initiator FSM state type
//   - response watchdog limit, used only when C2_TIMEOUT_EN is defined
package c2_pkg;

  localparam int ADDR_SIZE       = 15;  // 19-bit byte address minus 4 offset bits
  localparam int BUS_SIZE        = 16;
  localparam int CACHE_LINE_SIZE = 16;  // bytes
  localparam int LINE_BITS       = CACHE_LINE_SIZE * 8;
  localparam int BEATS           = LINE_BITS / BUS_SIZE;
  localparam int BEAT_CNT_W      = $clog2(BEATS);
  localparam int TIMEOUT_CYCLES  = 255;
  localparam int WD_W            = 8;

  typedef enum logic [1:0] {
    C2_NOP      = 2'd0,
    C2_RESPONSE = 2'd1,
    C2_READ     = 2'd2,
    C2_WRITE    = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_XFER_RD,
    ST_XFER_WR,
    ST_DONE
  } c2_state_e;

endpackage

// File: rtl/c2_tristate_drv.sv
// c2_tristate_drv: drives a shared bus with value while oe is high and
// releases it (high impedance) otherwise.
// Ports:
//   oe     in     1      output enable
//   value  in     WIDTH  value driven while enabled
//   pad    inout  WIDTH  shared bus
module c2_tristate_drv #(
  parameter int WIDTH = 16
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] value,
  inout  wire  [WIDTH-1:0] pad
);

  assign pad = oe ? value : {WIDTH{1'bz}};

endmodule

// File: rtl/c2_mem_initiator.sv
// c2_mem_initiator: cache-side master of the C2 memory bus. Converts a
// one-cycle line read/write request into a C2_READ/C2_WRITE transaction,
// waits for C2_RESPONSE and then moves the 128-bit line as 8 beats of
// 16 bits (beat 0 = line LSBs) over the shared data bus.
// Optional build macro: C2_TIMEOUT_EN adds a response watchdog and err port.
// Ports:
//   clk        in     1    clock, all logic on posedge
//   reset      in     1    synchronous, active-high
//   req_read   in     1    line read request (sampled in IDLE only)
//   req_write  in     1    line write request (sampled in IDLE only, wins)
//   req_addr   in     15   line address
//   wr_line    in     128  line to write, latched at acceptance
//   rd_line    out    128  line read, valid from done to next accepted read
//   busy       out    1    acceptance .. done
//   done       out    1    one-cycle completion pulse
//   address    out    15   C2 line address, held through the transaction
//   data       inout  16   C2 data bus
//   command    inout  2    C2 command bus
//   err        out    1    watchdog expired (C2_TIMEOUT_EN only)
module c2_mem_initiator
  import c2_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LINE_BITS-1:0] wr_line,
  output logic [LINE_BITS-1:0] rd_line,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]  data,
  inout  wire  [1:0]           command
`ifdef C2_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  c2_state_e              state_reg, state_next;
  logic [BEAT_CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic                   is_write_reg, is_write_next;
  logic [ADDR_SIZE-1:0]   addr_reg, addr_next;
  logic [LINE_BITS-1:0]   wr_line_reg, wr_line_next;
  logic                   capture;
  logic                   data_oe;
  logic                   cmd_oe;
  c2_cmd_e                cmd_value;
  logic [BUS_SIZE-1:0]    wr_beat [BEATS];

`ifdef C2_TIMEOUT_EN
  logic [WD_W-1:0]        wd_reg, wd_next;
  logic                   err_reg, err_next;
`endif

  genvar gi;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      wr_line_reg  <= '0;
`ifdef C2_TIMEOUT_EN
      wd_reg       <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      wr_line_reg  <= wr_line_next;
`ifdef C2_TIMEOUT_EN
      wd_reg       <= wd_next;
      err_reg      <= err_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    wr_line_next  = wr_line_reg;
    capture       = 1'b0;
`ifdef C2_TIMEOUT_EN
    wd_next       = wd_reg;
    err_next      = err_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (req_write || req_read) begin
          state_next    = ST_ISSUE;
          is_write_next = req_write;  // write wins over a simultaneous read
          addr_next     = req_addr;
          wr_line_next  = wr_line;
          beat_cnt_next = '0;
`ifdef C2_TIMEOUT_EN
          err_next      = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_RESP;
`ifdef C2_TIMEOUT_EN
        wd_next    = '0;
`endif
      end
      ST_WAIT_RESP: begin
        if (command == C2_RESPONSE) begin
          // The response edge is also the first beat edge.
          capture       = !is_write_reg;
          beat_cnt_next = BEAT_CNT_W'(1);
          state_next    = is_write_reg ? ST_XFER_WR : ST_XFER_RD;
        end
`ifdef C2_TIMEOUT_EN
        else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
`endif
      end
      ST_XFER_RD: begin
        capture       = 1'b1;
        beat_cnt_next = beat_cnt_reg + BEAT_CNT_W'(1);
        if (beat_cnt_reg == BEAT_CNT_W'(BEATS - 1)) state_next = ST_DONE;
      end
      ST_XFER_WR: begin
        beat_cnt_next = beat_cnt_reg + BEAT_CNT_W'(1);
        if (beat_cnt_reg == BEAT_CNT_W'(BEATS - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Read beats land in their own slice of rd_line as they arrive.
  for (gi = 0; gi < BEATS; gi++) begin : g_rd_beat
    logic [BUS_SIZE-1:0] beat_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        beat_reg <= '0;
      end else if (capture && beat_cnt_reg == BEAT_CNT_W'(gi)) begin
        beat_reg <= data;
      end
    end
    assign rd_line[gi*BUS_SIZE +: BUS_SIZE] = beat_reg;
  end

  for (gi = 0; gi < BEATS; gi++) begin : g_wr_beat
    assign wr_beat[gi] = wr_line_reg[gi*BUS_SIZE +: BUS_SIZE];
  end

  // Beat 0 is already on the bus while waiting so the memory can take it on
  // the response edge.
  assign data_oe   = is_write_reg &&
                     (state_reg == ST_WAIT_RESP || state_reg == ST_XFER_WR);
  assign cmd_oe    = (state_reg == ST_ISSUE);
  assign cmd_value = is_write_reg ? C2_WRITE : C2_READ;

  c2_tristate_drv #(.WIDTH(BUS_SIZE)) u_data_drv (
    .oe    (data_oe),
    .value (wr_beat[beat_cnt_reg]),
    .pad   (data)
  );

  c2_tristate_drv #(.WIDTH(2)) u_cmd_drv (
    .oe    (cmd_oe),
    .value (cmd_value),
    .pad   (command)
  );

  assign address = addr_reg;
  assign done    = (state_reg == ST_DONE);
  assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
`ifdef C2_TIMEOUT_EN
  assign err     = err_reg;
`endif

endmodule
